// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: round-robin arbiter sharing one TPU DMA port between two
// requesters. Each granted requester gets one DMA command, then a done pulse.
// Optional build macro DMA_ARB_TIMEOUT_EN adds a completion watchdog that
// ends a stalled transfer with an error pulse after TIMEOUT_CYCLES clocks.
module dma_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_req,
  input  logic         r0_dir,
  input  logic [7:0]   r0_ub_addr,
  input  logic [15:0]  r0_length,
  input  logic [1:0]   r0_elem_sz,
  input  logic [255:0] r0_wdata,
  output logic         r0_grant,
  output logic         r0_done,
  output logic         r0_err,
  input  logic         r1_req,
  input  logic         r1_dir,
  input  logic [7:0]   r1_ub_addr,
  input  logic [15:0]  r1_length,
  input  logic [1:0]   r1_elem_sz,
  input  logic [255:0] r1_wdata,
  output logic         r1_grant,
  output logic         r1_done,
  output logic         r1_err,
  output logic [255:0] rd_data,
  output logic         dma_start,
  output logic         dma_dir,
  output logic [7:0]   dma_ub_addr,
  output logic [15:0]  dma_length,
  output logic [1:0]   dma_elem_sz,
  output logic [255:0] dma_wdata,
  input  logic         dma_busy,
  input  logic         dma_done,
  input  logic [255:0] dma_rdata
);

  localparam int unsigned DataW = 256;
  localparam int unsigned AddrW = 8;
  localparam int unsigned LenW  = 16;
  localparam int unsigned ElemW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               owner, owner_n;   // 0 = r0 holds the port, 1 = r1
  logic               last, last_n;     // requester served most recently
  logic               win;
  logic               r0_grant_n, r1_grant_n;
  logic               r0_done_n, r1_done_n;
  logic               r0_err_n, r1_err_n;
  logic               dma_start_n;
  logic               dir_n;
  logic [AddrW-1:0]   addr_n;
  logic [LenW-1:0]    len_n;
  logic [ElemW-1:0]   esz_n;
  logic [DataW-1:0]   wdata_n;
  logic [DataW-1:0]   rd_n;

  // The port handshake is purely start/done; busy carries no extra information.
  logic unused_busy;
  assign unused_busy = dma_busy;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] wd_cnt, wd_cnt_n;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state, arbitration and command-latch logic.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    r0_grant_n  = r0_grant;
    r1_grant_n  = r1_grant;
    r0_done_n   = 1'b0;
    r1_done_n   = 1'b0;
    r0_err_n    = 1'b0;
    r1_err_n    = 1'b0;
    dma_start_n = 1'b0;
    dir_n       = dma_dir;
    addr_n      = dma_ub_addr;
    len_n       = dma_length;
    esz_n       = dma_elem_sz;
    wdata_n     = dma_wdata;
    rd_n        = rd_data;
`ifdef DMA_ARB_TIMEOUT_EN
    wd_cnt_n    = '0;
`endif
    // Contention goes to whoever was not served last.
    win = (r0_req && r1_req) ? ~last : r1_req;

    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          owner_n    = win;
          r0_grant_n = ~win;
          r1_grant_n = win;
          dir_n      = win ? r1_dir      : r0_dir;
          addr_n     = win ? r1_ub_addr  : r0_ub_addr;
          len_n      = win ? r1_length   : r0_length;
          esz_n      = win ? r1_elem_sz  : r0_elem_sz;
          wdata_n    = win ? r1_wdata    : r0_wdata;
          if ((win ? r1_length : r0_length) == LenW'(0)) begin
            // Empty transfer: complete without touching the DMA port.
            state_n   = FINISH;
            r0_done_n = ~win;
            r1_done_n = win;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        dma_start_n = 1'b1;
        if (dma_done) begin
          rd_n      = dma_rdata;
          state_n   = FINISH;
          r0_done_n = ~owner;
          r1_done_n = owner;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (dma_done) begin
          rd_n      = dma_rdata;
          state_n   = FINISH;
          r0_done_n = ~owner;
          r1_done_n = owner;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (wd_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_n    = IDLE;
          r0_grant_n = 1'b0;
          r1_grant_n = 1'b0;
          r0_err_n   = ~owner;
          r1_err_n   = owner;
          last_n     = owner;
        end else begin
          wd_cnt_n = wd_cnt + CntW'(1);
        end
`endif
      end
      FINISH: begin
        state_n    = IDLE;
        r0_grant_n = 1'b0;
        r1_grant_n = 1'b0;
        last_n     = owner;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      r0_grant    <= 1'b0;
      r1_grant    <= 1'b0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      r0_err      <= 1'b0;
      r1_err      <= 1'b0;
      dma_start   <= 1'b0;
      dma_dir     <= 1'b0;
      dma_ub_addr <= '0;
      dma_length  <= '0;
      dma_elem_sz <= '0;
      dma_wdata   <= '0;
      rd_data     <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last        <= last_n;
      r0_grant    <= r0_grant_n;
      r1_grant    <= r1_grant_n;
      r0_done     <= r0_done_n;
      r1_done     <= r1_done_n;
      r0_err      <= r0_err_n;
      r1_err      <= r1_err_n;
      dma_start   <= dma_start_n;
      dma_dir     <= dir_n;
      dma_ub_addr <= addr_n;
      dma_length  <= len_n;
      dma_elem_sz <= esz_n;
      dma_wdata   <= wdata_n;
      rd_data     <= rd_n;
`ifdef DMA_ARB_TIMEOUT_EN
      wd_cnt      <= wd_cnt_n;
`endif
    end
  end

endmodule

// File: doc/dma_port_arbiter.md
DMA_PORT_ARBITER -- requirements
Module: dma_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, DMA completion watchdog limit in clocks (used only when DMA_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rN_req  input  1  requester N (N=0,1) transfer request; held high until rN_done.
REQ-005 rN_dir  input  1  requester N direction (0 = host->UB, 1 = UB->host).
REQ-006 rN_ub_addr  input  8  requester N unified-buffer address.
REQ-007 rN_length  input  16  requester N transfer length in elements.
REQ-008 rN_elem_sz  input  2  requester N element size code.
REQ-009 rN_wdata  input  256  requester N write data.
REQ-010 rN_grant  output  1  requester N owns the DMA port.
REQ-011 rN_done  output  1  one-cycle completion pulse to requester N.
REQ-012 rN_err  output  1  one-cycle error pulse to requester N (timeout).
REQ-013 rd_data  output  256  read data captured at completion, shared by both requesters.
REQ-014 dma_start  output  1  one-cycle start pulse to the TPU DMA port.
REQ-015 dma_dir, dma_ub_addr, dma_length, dma_elem_sz, dma_wdata  output  1/8/16/2/256  registered command to the TPU DMA port.
REQ-016 dma_busy  input  1  TPU DMA busy.
REQ-017 dma_done  input  1  TPU DMA completion pulse.
REQ-018 dma_rdata  input  256  TPU DMA read data.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, FINISH.
REQ-020 IDLE: when any rN_req is high, select a winner, latch its command fields into the dma_* registers, assert rN_grant, and go to ISSUE on the next edge.
REQ-021 Arbitration: round-robin; when both requests are high, the requester not served last wins; after reset, r0 wins.
REQ-022 ISSUE: dma_start is high for exactly this one cycle; go to WAIT.
REQ-023 WAIT: hold grant and the dma_* command registers stable; when dma_done is high, capture dma_rdata into rd_data and go to FINISH.
REQ-024 A dma_done that arrives during ISSUE is accepted as in WAIT.
REQ-025 dma_done outside ISSUE or WAIT is ignored.
REQ-026 FINISH: pulse rN_done for one cycle, drop rN_grant at the following edge, record N as last served, and return to IDLE.
REQ-027 A new grant is never issued in the same cycle as FINISH, so there is a minimum of one IDLE cycle between transfers.
REQ-028 Latency: req high at edge k -> grant high after edge k -> dma_start high after edge k+1 -> rN_done high one cycle after the dma_done cycle.
REQ-029 rN_length == 0: go from IDLE directly to FINISH with no dma_start; rd_data is unchanged.
REQ-030 Once granted, a drop of rN_req is ignored and the transfer completes normally.
REQ-031 Changes to the ungranted requester's inputs have no effect.
REQ-032 At most one rN_grant is high at any time.
REQ-033 At most one of rN_done and rN_err is high in any cycle.

Reset
REQ-034 Asynchronous assertion of rst_n (low) forces IDLE and zeroes all outputs: grants, done, err, dma_start, dma_* command registers, and rd_data.
REQ-035 Last-served is reset to r1, so r0 wins first.
REQ-036 Reset mid-transfer abandons the transfer with no done or err pulse.
REQ-037 Deassertion of reset takes effect at the next clk edge.

Configuration
REQ-038 Macro DMA_ARB_TIMEOUT_EN defined: a counter runs in WAIT; if it reaches TIMEOUT_CYCLES without dma_done, pulse rN_err (not rN_done), leave rd_data unchanged, release the grant, and return to IDLE.
REQ-039 Macro DMA_ARB_TIMEOUT_EN undefined: no counter exists, rN_err is tied to 0, and WAIT persists until dma_done.

Verification
REQ-040 r0 request, addr 0x10, len 4, dir 0; dma_done 5 cycles after dma_start -> a single dma_start, dma_ub_addr 0x10, r0_done one cycle after dma_done, r0_grant never overlaps r1_grant.
REQ-041 r0 and r1 raised in the same cycle, each repeating 3 transfers -> grant order r0, r1, r0, r1, r0, r1.
REQ-042 r1 read with dma_rdata 0xA5..A5 at dma_done -> rd_data equals 0xA5..A5 at r1_done.
REQ-043 r0 request with length 0 -> no dma_start, r0_done 2 cycles after the request.
REQ-044 rst_n pulled low during WAIT -> all outputs 0 immediately; after release, r0 is granted first.
REQ-045 With DMA_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, dma_done withheld -> r0_err pulses 16 cycles into WAIT, no r0_done, next request is served.
